imem_loader: RTL and testbench

//  Write side of the instruction memory: receives a program image as a byte stream
//  (e.g. from a UART receiver) and writes it word-by-word into the instruction RAM

---
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction RAM: parses a length-prefixed,
// checksummed image, writes it word by word, and holds the core until it is valid.
module imem_loader #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 7
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [AWIDTH-1:0] waddr,
    output logic [DWIDTH-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam int unsigned BYTES = DWIDTH / 8;
    localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned DEPTH = 1 << AWIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state_q;
    logic              rx_ready_q, we_q, busy_q, done_q, err_q, cpu_hold_q;
    logic [AWIDTH-1:0] waddr_q;
    logic [DWIDTH-1:0] wdata_q, asm_q, asm_d;
    logic [BW-1:0]     byte_cnt_q;
    logic [15:0]       word_cnt_q, word_cnt_d, len_q, len_d;
    logic [7:0]        csum_q, csum_d;

    // Incoming byte merged into its lane, so a completed word can be written directly.
    always_comb begin
        asm_d = asm_q;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (byte_cnt_q == BW'(i)) asm_d[i*8 +: 8] = rx_data;
        end
        csum_d     = csum_q + rx_data;
        len_d      = {rx_data, len_q[7:0]};
        word_cnt_d = word_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            asm_q      <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q    <= S_LEN_LO;
                        rx_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        cpu_hold_q <= 1'b1;
                        byte_cnt_q <= '0;
                        word_cnt_q <= '0;
                        len_q      <= '0;
                        csum_q     <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (rx_valid) begin
                        len_q[7:0] <= rx_data;
                        csum_q     <= csum_d;
                        state_q    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (rx_valid) begin
                        len_q  <= len_d;
                        csum_q <= csum_d;
                        if (32'(len_d) > DEPTH) begin
                            state_q    <= S_ERR;
                            err_q      <= 1'b1;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else if (len_d == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        csum_q <= csum_d;
                        asm_q  <= asm_d;
                        if (byte_cnt_q == BW'(BYTES - 1)) begin
                            we_q       <= 1'b1;
                            waddr_q    <= word_cnt_q[AWIDTH-1:0];
                            wdata_q    <= asm_d;
                            byte_cnt_q <= '0;
                            word_cnt_q <= word_cnt_d;
                            if (word_cnt_d == len_q) state_q <= S_CSUM;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BW'(1);
                        end
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (rx_data == csum_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_ready = rx_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected imem writes are queued as frames are
// sent and popped by a monitor on every we pulse; status levels are checked inline.
module tb_imem_loader;

    localparam int unsigned DWIDTH = 32;
    localparam int unsigned AWIDTH = 7;

    logic              clk = 1'b0;
    logic              nrst, start, rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready, we, busy, done, err, cpu_hold;
    logic [AWIDTH-1:0] waddr;
    logic [DWIDTH-1:0] wdata;

    imem_loader #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .nrst(nrst), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_we: got waddr 0x%0h wdata 0x%0h expected no write",
                         waddr, wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("waddr", 32'(waddr), 32'(e.addr));
                chk("wdata", wdata, e.data);
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        int waited;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (rx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic send_frame(input int nbytes, input int maxgap);
        for (int i = 0; i < nbytes; i++) send_byte(frame[i], maxgap);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic build_t2(input logic [7:0] csum, input bit expect_writes);
        frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, csum};
        if (expect_writes) begin
            exp_q.push_back('{addr: 7'd0, data: 32'h0000_0013});
            exp_q.push_back('{addr: 7'd1, data: 32'h0010_0093});
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_err"}, 32'(err), 32'(e));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = '0;

        // T1 reset
        repeat (2) @(negedge clk);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", 32'(rx_ready), 32'd0);

        // T2 nominal; checksum 02+13+93+10 = B8
        build_t2(8'hB8, 1'b1);
        do_start();
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_rx_ready", 32'(rx_ready), 32'd1);
        send_frame(frame.size(), 0);
        check_status("t2", 1'b1, 1'b0, 1'b0);
        drain("t2");

        // T3 bad checksum
        build_t2(8'hB9, 1'b1);
        do_start();
        chk("t3_done_cleared", 32'(done), 32'd0);
        chk("t3_cpu_hold_start", 32'(cpu_hold), 32'd1);
        send_frame(frame.size(), 0);
        check_status("t3", 1'b0, 1'b1, 1'b1);
        drain("t3");

        // T4 overflow: N=129 > 128
        frame = '{8'h81, 8'h00};
        do_start();
        chk("t4_err_cleared", 32'(err), 32'd0);
        send_frame(2, 0);
        check_status("t4", 1'b0, 1'b1, 1'b1);
        drain("t4");

        // T4b boundary: N=128 accepted, so rx_ready stays high in DATA
        frame = '{8'h80, 8'h00};
        do_start();
        send_frame(2, 0);
        chk("t4b_err", 32'(err), 32'd0);
        chk("t4b_busy", 32'(busy), 32'd1);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // T5 empty image, then T2 with random gaps
        frame = '{8'h00, 8'h00, 8'h00};
        do_start();
        send_frame(3, 0);
        check_status("t5_empty", 1'b1, 1'b0, 1'b0);
        drain("t5_empty");
        // start while busy is ignored: it must not restart the frame
        build_t2(8'hB8, 1'b1);
        do_start();
        send_byte(frame[0], 0);
        @(negedge clk);
        rx_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < frame.size(); i++) send_byte(frame[i], 5);
        @(negedge clk);
        rx_valid = 1'b0;
        check_status("t5_gaps", 1'b1, 1'b0, 1'b0);
        drain("t5_gaps");

        // T6 reset mid-DATA after word 0 completes
        build_t2(8'hB8, 1'b0);
        exp_q.push_back('{addr: 7'd0, data: 32'h0000_0013});
        do_start();
        for (int i = 0; i < 7; i++) send_byte(frame[i], 0);
        @(negedge clk);
        rx_valid = 1'b0;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_status("t6_rst", 1'b0, 1'b0, 1'b1);
        drain("t6_rst");
        build_t2(8'hB8, 1'b1);
        do_start();
        send_frame(frame.size(), 0);
        check_status("t6_rerun", 1'b1, 1'b0, 1'b0);
        drain("t6_rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
